// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared widths, constants and load-op codes for the MEM/WB stage
// Purpose: register-file widths, bubble values, reset/write-enable levels,
//          load-op encodings and the write-back record type.
// Ports:   none (package).
package mem_wb_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

  localparam logic WriteEnable = 1'b1;
  localparam logic RstEnable   = 1'b1;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;

  typedef struct packed {
    logic                  we;
    logic [RegAddrBus-1:0] waddr;
    logic [RegBus-1:0]     wdata;
  } wb_t;

endpackage

// File: rtl/mem_wb_if.sv
// rtl/mem_wb_if.sv - MEM-stage, data-memory response and write-back signal bundle
// Purpose: groups everything mem_wb exchanges with the MEM stage, the data
//          memory, the stall controller and the register file.
// Ports:   master = pipeline/environment side, slave = mem_wb side.
interface mem_wb_if;
  import mem_wb_pkg::*;

  logic                  mem_we;
  logic [RegAddrBus-1:0] mem_waddr;
  logic [RegBus-1:0]     mem_wdata;
  logic                  mem_load;
  logic [2:0]            mem_load_op;
  logic [1:0]            mem_addr_lo;
  logic [RegBus-1:0]     dmem_rdata;
  logic                  dmem_rvalid;
  logic                  stall_mem;
  logic                  flush;
  logic                  stall_req;
  logic                  wb_we;
  logic [RegAddrBus-1:0] wb_waddr;
  logic [RegBus-1:0]     wb_wdata;

  modport master (
    output mem_we, mem_waddr, mem_wdata, mem_load, mem_load_op, mem_addr_lo,
    output dmem_rdata, dmem_rvalid, stall_mem, flush,
    input  stall_req, wb_we, wb_waddr, wb_wdata
  );

  modport slave (
    input  mem_we, mem_waddr, mem_wdata, mem_load, mem_load_op, mem_addr_lo,
    input  dmem_rdata, dmem_rvalid, stall_mem, flush,
    output stall_req, wb_we, wb_waddr, wb_wdata
  );

endinterface

// File: rtl/mem_wb_load_align.sv
// rtl/mem_wb_load_align.sv - little-endian load data extractor
// Purpose: picks the byte/halfword/word addressed by a load out of the
//          returned memory word and sign- or zero-extends it.
// Ports:   load_op (3) op code, addr_lo (2) address bits [1:0],
//          rdata (32) memory word, result (32) aligned value.
module mem_wb_load_align
  import mem_wb_pkg::*;
(
  input  logic [2:0]        load_op,
  input  logic [1:0]        addr_lo,
  input  logic [RegBus-1:0] rdata,
  output logic [RegBus-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    // addr_lo[0] is ignored for halfwords: misaligned halfwords trap upstream.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (load_op)
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'h0, byte_sel};
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'h0, half_sel};
      OP_LW:   result = rdata;
      default: result = ZeroWord;
    endcase
  end

endmodule

// File: rtl/mem_wb.sv
// rtl/mem_wb.sv - MEM/WB pipeline register with variable-latency load handling
// Purpose: registers the MEM result onto the register-file write port, waits
//          for load data, buffers it across external stalls and discards the
//          response of a flushed load.
// Ports:   clk, rst (async, active-high); bus (mem_wb_if.slave) carrying MEM
//          inputs, dmem response, stall/flush control, stall_req and wb_*.
module mem_wb
  import mem_wb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  mem_wb_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HELD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam wb_t WB_BUBBLE = '{we: ~WriteEnable, waddr: NOPRegAddr, wdata: ZeroWord};

  state_e            state_q, state_d;
  logic [RegBus-1:0] buf_q, buf_d;
  wb_t               wb_q, wb_d;
  logic [RegBus-1:0] aligned;
  logic [RegBus-1:0] load_data;
  logic              data_ready;
  logic              stall_req;

  mem_wb_load_align u_align (
    .load_op (bus.mem_load_op),
    .addr_lo (bus.mem_addr_lo),
    .rdata   (bus.dmem_rdata),
    .result  (aligned)
  );

  assign bus.stall_req = stall_req;
  assign bus.wb_we     = wb_q.we;
  assign bus.wb_waddr  = wb_q.waddr;
  assign bus.wb_wdata  = wb_q.wdata;

  // Kept apart from the next-state logic: the controller feeds stall_req
  // back into stall_mem, so stall_req must not depend on stall_mem.
  always_comb begin
    stall_req = 1'b0;
    case (state_q)
      ST_IDLE:  stall_req = bus.mem_load & ~bus.dmem_rvalid;
      ST_WAIT:  stall_req = ~bus.dmem_rvalid;
      ST_HELD:  stall_req = 1'b0;
      ST_DRAIN: stall_req = bus.mem_load;
      default:  stall_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    wb_d       = WB_BUBBLE;
    load_data  = aligned;
    data_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        data_ready = bus.dmem_rvalid;
        if (bus.mem_load && !bus.dmem_rvalid) begin
          state_d = ST_WAIT;
        end else if (bus.mem_load && bus.dmem_rvalid && bus.stall_mem) begin
          state_d = ST_HELD;
          buf_d   = aligned;
        end
      end
      ST_WAIT: begin
        data_ready = bus.dmem_rvalid;
        if (bus.dmem_rvalid) begin
          if (bus.stall_mem) begin
            state_d = ST_HELD;
            buf_d   = aligned;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HELD: begin
        data_ready = 1'b1;
        load_data  = buf_q;
        if (!bus.stall_mem) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        // The response arriving here belongs to the flushed load.
        if (bus.dmem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.flush) begin
      buf_d = ZeroWord;
      // A response is still owed only if the old load had not seen it yet.
      if ((state_q == ST_WAIT || state_q == ST_DRAIN) && !bus.dmem_rvalid)
        state_d = ST_DRAIN;
      else
        state_d = ST_IDLE;
    end else if (bus.stall_mem) begin
      wb_d = WB_BUBBLE;
    end else if (!bus.mem_load) begin
      wb_d.we    = bus.mem_we;
      wb_d.waddr = bus.mem_waddr;
      wb_d.wdata = bus.mem_wdata;
    end else if (data_ready) begin
      wb_d.we    = bus.mem_we;
      wb_d.waddr = bus.mem_waddr;
      wb_d.wdata = load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q <= ST_IDLE;
      buf_q   <= ZeroWord;
      wb_q    <= WB_BUBBLE;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      wb_q    <= wb_d;
    end
  end

endmodule

// File: doc/mem_wb.md
# mem_wb

MEM/WB pipeline stage: registers the memory-stage result and drives the register file write port (`we`/`waddr`/`wdata`) one cycle later. For loads, it waits on a variable-latency data-memory response, aligns and extends the returned byte, halfword or word, and requests a pipeline stall until the data arrives. It sits between the MEM stage and the register file, and is the last stage of the pipeline.

## Interface
Parameters:
- None. Widths come from shared constants: `RegBus` is 32 bits, `RegAddrBus` is 5 bits.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_we`  in  1  MEM-stage instruction writes a GPR.
- `mem_waddr`  in  5  destination GPR.
- `mem_wdata`  in  32  ALU/move result, used for non-loads.
- `mem_load`  in  1  MEM-stage instruction is a load.
- `mem_load_op`  in  3  LB=000, LBU=001, LH=010, LHU=011, LW=100; all other codes are reserved.
- `mem_addr_lo`  in  2  effective address bits [1:0].
- `dmem_rdata`  in  32  data-memory read word.
- `dmem_rvalid`  in  1  single-cycle pulse; read word is valid this cycle.
- `stall_mem`  in  1  controller is holding the MEM stage (any stall source, including this block's own `stall_req`).
- `flush`  in  1  pipeline flush (exception or eret).
- `stall_req`  out  1  request to the controller to hold MEM and all earlier stages.
- `wb_we`  out  1  to regfile `we`.
- `wb_waddr`  out  5  to regfile `waddr`.
- `wb_wdata`  out  32  to regfile `wdata`.

## Operation
- Bubble: `wb_we=0`, `wb_waddr=0`, `wb_wdata=0`.
- Control states:
  - IDLE: no load outstanding.
  - WAIT: a load is waiting for `dmem_rvalid`.
  - HELD: aligned load data is buffered while `stall_mem` is high.
  - DRAIN: a flushed load's response is still due and must be discarded.
- `stall_req` is combinational:
  - In IDLE: `stall_req = mem_load & ~dmem_rvalid`.
  - In WAIT: `stall_req = ~dmem_rvalid`.
  - In HELD: `stall_req = 0`.
  - In DRAIN: `stall_req = mem_load`.
- Transitions:
  - IDLE→WAIT: `mem_load & ~dmem_rvalid`.
  - IDLE or WAIT→HELD: `dmem_rvalid & stall_mem`; the aligned data is latched into the buffer.
  - HELD→IDLE: `~stall_mem`.
  - WAIT→IDLE: `dmem_rvalid & ~stall_mem`.
  - WAIT→DRAIN: `flush`.
  - DRAIN→IDLE: `dmem_rvalid`, which is discarded.
- Pipeline register update, in priority order:
  - `flush`: bubble; FSM goes to IDLE, or DRAIN if it was in WAIT; buffer cleared.
  - `stall_mem`: bubble.
  - Non-load: capture `mem_we`, `mem_waddr`, `mem_wdata`.
  - Load: capture aligned data when it is available (`dmem_rvalid` in IDLE or WAIT, or the buffer in HELD). Otherwise bubble.
- Alignment is little-endian:
  - LB/LBU: byte `mem_addr_lo`; LB sign-extends, LBU zero-extends.
  - LH/LHU: halfword selected by `mem_addr_lo[1]`; LH sign-extends, LHU zero-extends. `mem_addr_lo[0]` is ignored (misalignment is trapped upstream).
  - LW: whole word.
  - Reserved op codes: result is ZeroWord; `wb_we` follows `mem_we`.
- `mem_waddr=0` is passed through unchanged; the register file ignores writes to register 0.

## Timing
- Reset: all outputs 0 (bubble, `stall_req=0`), FSM IDLE, buffer 0, taking effect immediately on `rst` assertion.
- Non-load latency: MEM inputs at edge N appear on `wb_*` after edge N+1.
- Zero-wait load: `dmem_rvalid` in the same cycle as `mem_load` means no stall.
- Multi-cycle load: `stall_req` is high from the first cycle until the `dmem_rvalid` cycle. Data appears on `wb_*` after the first edge at which both `dmem_rvalid` and `~stall_mem` hold, or when HELD exits.
- The register file forwards `wdata` combinationally, so the ID stage sees `wb_*` in the same cycle.
- `flush` together with `dmem_rvalid` in WAIT: the data is discarded and the FSM goes to IDLE, not DRAIN.
- `rst` asserted mid-load: the FSM returns to IDLE; the memory interface is reset by the same `rst`.

## Structure
- Shared package / `define.v` holds: `RegBus`, `RegAddrBus`, `ZeroWord`, `NOPRegAddr`, the load-op codes, and the WriteEnable/RstEnable levels.
- FSM state encoding is local to this block.
- One sub-module, `load_align`: combinational extractor from (`load_op`, `addr_lo`, `rdata`) to a 32-bit result. It is shared by the direct-capture and buffer paths.

## Test plan
- ALU write: `mem_we=1`, `mem_waddr=5`, `mem_wdata=0x1234_5678` → next cycle `wb_we=1`, `wb_waddr=5`, `wb_wdata=0x1234_5678`; `stall_req=0` throughout.
- LB with 3-cycle latency: `rdata=0x80FF_7F01`, `addr_lo=3` → `stall_req` high for 2 cycles; then `wb_wdata=0xFFFF_FF80`. Repeat with LBU → `0x0000_0080`.
- LH/LHU with `addr_lo=2` on `0x80FF_7F01` → `0xFFFF_80FF` and `0x0000_80FF`. LW with zero-wait → `0x80FF_7F01`, no stall.
- Response under external stall: `dmem_rvalid` arrives while `stall_mem=1` for 2 further cycles → bubbles during the stall; data is written in the cycle after `stall_mem` falls; the FSM passes through HELD.
- Flush in WAIT: flush, then `dmem_rvalid` 2 cycles later with a new non-load in MEM → stale data never reaches `wb_*`; the new instruction writes normally.
- Asynchronous reset mid-WAIT → outputs 0 immediately; after release, the first load restarts cleanly.
